// File: rtl/ring_bus_pkg.sv
// Shared widths, FSM state type and pointer helper for the ring-bus
// write-port arbiter and its round-robin picker.
package ring_bus_pkg;

  localparam int RB_ADDR_W = 8;
  localparam int RB_DATA_W = 32;
  localparam int RB_IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    GAP
  } rb_state_e;

  // Pointer to the slot after w, wrapping at n.
  function automatic logic [RB_IDX_W-1:0] rb_next_ptr(
    input logic [RB_IDX_W-1:0] w,
    input int                  n
  );
    if (int'(w) + 1 >= n) return '0;
    return w + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr.
// Ports: i_req (requests), i_ptr (start slot), o_grant (one-hot), o_idx, o_any.
module rr_arbiter
  import ring_bus_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [RB_IDX_W-1:0] i_ptr,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [RB_IDX_W-1:0] o_idx,
  output logic                o_any
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [RB_IDX_W-1:0]  w_off;
  logic                 w_found;
  logic [RB_IDX_W:0]    w_sum;

  // Rotate so bit 0 is the pointer slot; first set bit is the winner.
  assign w_dbl = {i_req, i_req};
  assign w_rot = NUM_REQ'(w_dbl >> i_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = RB_IDX_W'(i);
      end
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_any = w_found;

  always_comb begin
    if (w_sum >= (RB_IDX_W+1)'(NUM_REQ)) begin
      o_idx = RB_IDX_W'(w_sum - (RB_IDX_W+1)'(NUM_REQ));
    end else begin
      o_idx = w_sum[RB_IDX_W-1:0];
    end
  end

  always_comb begin
    o_grant = '0;
    if (w_found) o_grant = NUM_REQ'(1) << o_idx;
  end

endmodule

// File: rtl/ring_bus_wr_arbiter.sv
// Shares the ring-bus write port between NUM_REQ requesters (round robin),
// holds each frame until accepted, enforces a post-accept gap, flags stalls.
// Ports: i_req_* requester side, o_wr_*/o_start_wr/i_write_ready ring side,
// o_grant_id/o_busy/o_timeout/o_wr_count status, i_clear_timeout control.
module ring_bus_wr_arbiter
  import ring_bus_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MIN_GAP     = 6,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                           i_sysclk,
  input  logic                           i_srst,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ*RB_ADDR_W-1:0]   i_req_addr,
  input  logic [NUM_REQ*RB_DATA_W-1:0]   i_req_data,
  output logic [RB_ADDR_W-1:0]           o_wr_addr,
  output logic [RB_DATA_W-1:0]           o_wr_data,
  output logic                           o_start_wr,
  input  logic                           i_write_ready,
  output logic [RB_IDX_W-1:0]            o_grant_id,
  output logic                           o_busy,
  output logic                           o_timeout,
  input  logic                           i_clear_timeout,
  output logic [15:0]                    o_wr_count
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  rb_state_e             r_state;
  logic [RB_IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0]    r_req_ready;
  logic [RB_ADDR_W-1:0]  r_wr_addr;
  logic [RB_DATA_W-1:0]  r_wr_data;
  logic                  r_start_wr;
  logic [RB_IDX_W-1:0]   r_grant_id;
  logic                  r_busy;
  logic                  r_timeout;
  logic [15:0]           r_wr_count;
  logic [TW-1:0]         r_to_cnt;
  logic [GW-1:0]         r_gap_cnt;

  logic [NUM_REQ-1:0]    w_grant;
  logic [RB_IDX_W-1:0]   w_idx;
  logic                  w_any;
  logic [RB_ADDR_W-1:0]  w_sel_addr;
  logic [RB_DATA_W-1:0]  w_sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_sel_addr = RB_ADDR_W'(i_req_addr >> (w_idx * RB_ADDR_W));
  assign w_sel_data = RB_DATA_W'(i_req_data >> (w_idx * RB_DATA_W));

  always_ff @(posedge i_sysclk or posedge i_srst) begin
    if (i_srst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_req_ready <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_start_wr  <= 1'b0;
      r_grant_id  <= '0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_wr_count  <= '0;
      r_to_cnt    <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_start_wr  <= 1'b0;
      r_req_ready <= '0;
      // Clear first so a same-cycle timeout set below takes priority.
      if (i_clear_timeout) r_timeout <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_wr_addr   <= w_sel_addr;
            r_wr_data   <= w_sel_data;
            r_grant_id  <= w_idx;
            r_ptr       <= rb_next_ptr(w_idx, NUM_REQ);
            r_start_wr  <= 1'b1;
            r_req_ready <= w_grant;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE, WAIT_ACK: begin
          if (i_write_ready) begin
            r_wr_count <= r_wr_count + 16'd1;
            r_to_cnt   <= '0;
            r_gap_cnt  <= '0;
            if (MIN_GAP == 0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= GAP;
            end
          end else if (r_state == ISSUE) begin
            r_state  <= WAIT_ACK;
            r_to_cnt <= '0;
          end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (r_to_cnt == TO_LAST) r_timeout <= 1'b1;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_start_wr  = r_start_wr;
  assign o_grant_id  = r_grant_id;
  assign o_busy      = r_busy;
  assign o_timeout   = r_timeout;
  assign o_wr_count  = r_wr_count;

endmodule

// File: tb/tb_ring_bus_wr_arbiter.sv
// Bench for ring_bus_wr_arbiter: random requesters and an emulated ring-bus
// acknowledger, checked cycle by cycle against a transaction-level model.
module tb_ring_bus_wr_arbiter;

  localparam int N  = 4;
  localparam int MG = 6;
  localparam int TO = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  valid = '0;
  logic [7:0]    fa [N];
  logic [31:0]   fd [N];
  logic [N*8-1:0]  addr_bus;
  logic [N*32-1:0] data_bus;
  logic          ack = 1'b0;
  logic          clr = 1'b0;

  logic [N-1:0]  o_req_ready;
  logic [7:0]    o_wr_addr;
  logic [31:0]   o_wr_data;
  logic          o_start_wr;
  logic [2:0]    o_grant_id;
  logic          o_busy;
  logic          o_timeout;
  logic [15:0]   o_wr_count;

  ring_bus_wr_arbiter #(
    .NUM_REQ     (N),
    .MIN_GAP     (MG),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_sysclk        (clk),
    .i_srst          (rst),
    .i_req_valid     (valid),
    .o_req_ready     (o_req_ready),
    .i_req_addr      (addr_bus),
    .i_req_data      (data_bus),
    .o_wr_addr       (o_wr_addr),
    .o_wr_data       (o_wr_data),
    .o_start_wr      (o_start_wr),
    .i_write_ready   (ack),
    .o_grant_id      (o_grant_id),
    .o_busy          (o_busy),
    .o_timeout       (o_timeout),
    .i_clear_timeout (clr),
    .o_wr_count      (o_wr_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    addr_bus = '0;
    data_bus = '0;
    for (int r = 0; r < N; r++) begin
      addr_bus[r*8 +: 8]   = fa[r];
      data_bus[r*32 +: 32] = fd[r];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model state
  int          cyc = 0;
  int          m_ptr, m_w, m_issue_c, m_wait, m_free_at, ack_dly;
  bit          m_busy, m_to;
  logic [15:0] m_cnt;
  logic [7:0]  m_addr;
  logic [31:0] m_data;

  int p_req = 0, p_spur = 0, dly_max = 3;
  bit stall = 0, clr_at_set = 0;
  int glog[$];

  task automatic model_reset();
    m_ptr = 0; m_w = 0; m_issue_c = 0; m_wait = 0;
    m_free_at = 0; ack_dly = 0;
    m_busy = 0; m_to = 0; m_cnt = '0;
    m_addr = '0; m_data = '0;
  endtask

  task automatic step();
    bit           es;
    bit           setn;
    int           w;
    logic [N-1:0] oh;
    es = 0; setn = 0; w = 0; oh = '0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (rst) begin
      model_reset();
      chk("rst_start", o_start_wr, 0);
      chk("rst_ready", o_req_ready, 0);
      chk("rst_addr", o_wr_addr, 0);
      chk("rst_data", o_wr_data, 0);
      chk("rst_gid", o_grant_id, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_to", o_timeout, 0);
      chk("rst_cnt", o_wr_count, 0);
      ack = 0;
      clr = 0;
      return;
    end
    // Apply the inputs that were present at this edge to the model
    if (clr) m_to = 0;
    if (m_busy) begin
      if (ack) begin
        m_cnt++;
        m_busy = 0;
        m_free_at = cyc + MG + 1;
      end else if (cyc > m_issue_c + 1 && m_wait < TO) begin
        m_wait++;
        setn = (m_wait == TO);
      end
    end else if (cyc >= m_free_at && valid != 0) begin
      for (int k = 0; k < N; k++) begin
        if (!es && valid[(m_ptr + k) % N]) begin
          es = 1;
          w = (m_ptr + k) % N;
        end
      end
      m_busy = 1;
      m_w = w;
      m_issue_c = cyc;
      m_wait = 0;
      m_ptr = (w + 1) % N;
      m_addr = fa[w];
      m_data = fd[w];
      glog.push_back(w);
    end
    if (setn) m_to = 1;
    if (es) oh[w] = 1'b1;

    chk("start_wr", o_start_wr, es);
    chk("req_ready", o_req_ready, oh);
    chk("busy", o_busy, m_busy || (cyc < m_free_at - 1));
    chk("timeout", o_timeout, m_to);
    chk("wr_count", o_wr_count, m_cnt);
    chk("grant_id", o_grant_id, m_w);
    chk("wr_addr", o_wr_addr, m_addr);
    chk("wr_data", o_wr_data, m_data);

    // Requesters: drop on ready, maybe raise a fresh frame
    if (es) valid[w] = 0;
    for (int r = 0; r < N; r++) begin
      if (!valid[r] && $urandom_range(99) < p_req) begin
        valid[r] = 1;
        fa[r] = 8'($urandom);
        fd[r] = $urandom;
      end
    end
    // Ring-bus acknowledger
    clr = 0;
    if (m_busy) begin
      if (es) ack_dly = $urandom_range(dly_max);
      if (stall) ack = 0;
      else if (ack_dly == 0) ack = 1;
      else begin
        ack = 0;
        ack_dly--;
      end
    end else begin
      ack = ($urandom_range(99) < p_spur);
    end
    if (clr_at_set && m_busy && m_wait == TO - 1) clr = 1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
    glog.delete();
  endtask

  logic [7:0]  sv_addr;
  logic [15:0] sv_cnt;

  initial begin
    for (int r = 0; r < N; r++) begin
      fa[r] = '0;
      fd[r] = '0;
    end
    model_reset();
    step();
    step();
    rst = 0;

    // Single frame from requester 1
    valid[1] = 1; fa[1] = 8'h01; fd[1] = 32'hDEADBEEF;
    run(20);
    chk("single_cnt", o_wr_count, 1);
    chk("single_gid", (glog.size() == 1) ? glog[0] : 99, 1);
    chk("single_data", o_wr_data, 32'hDEADBEEF);

    // All four contending continuously
    do_reset();
    for (int r = 0; r < N; r++) begin
      valid[r] = 1;
      fa[r] = 8'($urandom);
      fd[r] = $urandom;
    end
    p_req = 100;
    run(200);
    p_req = 0;
    chk("cont_n", glog.size() >= 8, 1);
    for (int k = 0; k < 8; k++)
      chk("cont_order", (k < glog.size()) ? glog[k] : -1, k % 4);
    run(60);

    // Fairness: after grant 2, requests 0 and 3 -> 3 first
    do_reset();
    valid = '0;
    valid[2] = 1;
    run(20);
    valid[0] = 1;
    valid[3] = 1;
    run(40);
    chk("fair_n", glog.size(), 3);
    chk("fair_0", (glog.size() > 0) ? glog[0] : -1, 2);
    chk("fair_1", (glog.size() > 1) ? glog[1] : -1, 3);
    chk("fair_2", (glog.size() > 2) ? glog[2] : -1, 0);

    // Spurious acks while idle
    sv_cnt = o_wr_count;
    p_spur = 100;
    run(15);
    p_spur = 0;
    run(1);
    chk("spur_cnt", o_wr_count, sv_cnt);
    chk("spur_busy", o_busy, 0);

    // Stall until timeout, then late ack and clear
    dly_max = 0;
    stall = 1;
    valid[0] = 1; fa[0] = 8'h5A; fd[0] = 32'h1234_5678;
    sv_addr = 8'h5A;
    run(TO + 5);
    chk("stall_to", o_timeout, 1);
    chk("stall_addr", o_wr_addr, sv_addr);
    chk("stall_data", o_wr_data, 32'h1234_5678);
    stall = 0;
    run(3);
    chk("stall_gap_busy", o_busy, 1);
    chk("stall_sticky", o_timeout, 1);
    clr = 1;
    step();
    chk("stall_clr", o_timeout, 0);

    // Clear on the same cycle as the timeout set: set wins
    run(20);
    clr_at_set = 1;
    stall = 1;
    valid[1] = 1; fa[1] = 8'h00; fd[1] = 32'hCAFE_0000;
    run(TO + 5);
    chk("setwins", o_timeout, 1);
    chk("addr0_pass", o_wr_addr, 0);
    clr_at_set = 0;
    stall = 0;
    run(20);
    clr = 1;
    step();

    // Reset while waiting for ack
    stall = 1;
    valid[3] = 1; fa[3] = 8'h33; fd[3] = 32'h3333_3333;
    run(10);
    chk("pre_rst_busy", o_busy, 1);
    rst = 1;
    step();
    rst = 0;
    stall = 0;
    dly_max = 3;
    glog.delete();
    valid[1] = 1; fa[1] = 8'h11; fd[1] = 32'h1111_1111;
    valid[2] = 1; fa[2] = 8'h22; fd[2] = 32'h2222_2222;
    run(40);
    chk("post_rst_0", (glog.size() > 0) ? glog[0] : -1, 1);
    chk("post_rst_1", (glog.size() > 1) ? glog[1] : -1, 2);
    chk("post_rst_cnt", o_wr_count, 2);

    // Random traffic
    p_req = 30;
    p_spur = 10;
    dly_max = 6;
    run(3000);
    p_req = 0;
    p_spur = 0;
    run(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
